noc_credit_link: RTL
====================

// Module: noc_credit_link
// PURPOSE
//  Pipelined, credit-checked rtr-to-rtr link between one router output port and the neighbouring
//  router's input port. Retimes flits forward and credits backward by NUM_PIPELINE register stages.
//  Tracks the upstream credit balance, flags protocol violations and counts flits.
//  One instance per mesh port (N/S/E/W), all in the clk_noc domain.
// PARAMETERS
//  NUM_PIPELINE       0   register stages in each direction; 0 = wire pass-through
//  FLIT_WIDTH         32  flit payload width
//  DEST_WIDTH         6   routing destination width (tdest + tid)
//  FLIT_BUFFER_DEPTH  4   downstream input FIFO depth = initial credit count
//  FLIT_CNT_WIDTH     32  flit counter width
// PORTS
//  clk_noc        in   1               NoC clock
//  rst_noc_sync   in   1               synchronous, active-high reset (one clock)
//  data_in        in   FLIT_WIDTH      flit from upstream router output
//  dest_in        in   DEST_WIDTH      destination of flit
//  is_tail_in     in   1               last flit of packet
//  send_in        in   1               flit valid (one flit per cycle)
//  credit_out     out  1               credit returned to upstream router
//  data_out       out  FLIT_WIDTH      flit to downstream router input
//  dest_out       out  DEST_WIDTH
//  is_tail_out    out  1
//  send_out       out  1
//  credit_in      in   1               credit from downstream router
//  credit_count   out  CNT_W           upstream-visible credits, CNT_W=$clog2(FLIT_BUFFER_DEPTH+1)
//  err_underflow  out  1               sticky: send_in seen with credit_count==0
//  err_overflow   out  1               sticky: credit_out seen with credit_count==FLIT_BUFFER_DEPTH
//  flit_count     out  FLIT_CNT_WIDTH  flits accepted on send_in (wraps)
// BEHAVIOUR
//  - Forward: {send,is_tail,dest,data} delayed exactly NUM_PIPELINE cycles. Backward: credit delayed
//    NUM_PIPELINE cycles. NUM_PIPELINE=0 -> purely combinational, zero latency both ways.
//  - No stall/backpressure: credit flow control. Every stage loads every cycle, no gating.
//  - Reset (rst_noc_sync=1 at a clk_noc edge): all stage regs 0 (send/is_tail/credit/data/dest).
//    With NUM_PIPELINE>0, send_out=is_tail_out=credit_out=0 and data_out=dest_out=0 the cycle after.
//    credit_count=FLIT_BUFFER_DEPTH, err_*=0, flit_count=0.
//  - Reset mid-operation: in-flight flits and credits dropped. Both routers share this reset,
//    so the balance restarts consistently.
//  - Credit monitor at upstream side, registered, 1-cycle update:
//      send_in & !credit_out -> count-1 ; !send_in & credit_out -> count+1 ; both or neither -> hold.
//      Underflow: send_in & !credit_out & count==0 -> err_underflow<=1, count holds at 0.
//      Overflow: credit_out & !send_in & count==DEPTH -> err_overflow<=1, count holds at DEPTH.
//      Errors clear only on reset. Flits still forwarded regardless of errors.
//  - flit_count += send_in each cycle, modulo 2^FLIT_CNT_WIDTH.
//  - Fill: consecutive send_in flits with NUM_PIPELINE=P arrive on consecutive cycles, order kept.
//  - Steady-state throughput is 1 flit/cycle only if FLIT_BUFFER_DEPTH >= 2P + router round trip.
//    Not enforced, documented only.
// STRUCTURE
//  - Shared package noc_link_pkg: typedef flit_t {logic send, is_tail; logic [DEST_WIDTH-1:0] dest;
//    logic [FLIT_WIDTH-1:0] data} as a parameterised-width struct macro.
//    Also function cnt_width(depth) returning $clog2(depth+1).
//  - Sub-module noc_link_stage: one forward flit_t register + one backward credit register,
//    sync reset. Instantiated NUM_PIPELINE times by a generate chain; P=0 branch assigns through.
//  - Credit monitor and flit counter are inline always_ff in the top.
// TESTING
//  1. P=2, DEPTH=4: send 3 flits back-to-back (tail on 3rd), dest=6'h15.
//     -> send_out high cycles 2,3,4, data and dest intact, is_tail_out only cycle 4, count 4->1.
//  2. P=2: pulse credit_in at cycle 10 -> credit_out high at cycle 12, credit_count +1 at cycle 13.
//  3. DEPTH=4: 5 sends with no credits.
//     -> count 4,3,2,1,0, err_underflow=1 after 5th, count stays 0, 5th flit still forwarded.
//  4. Simultaneous send_in and credit_out at count=2 -> count stays 2, no error.
//     Credit with count=4 and no send -> err_overflow=1.
//  5. Assert rst_noc_sync with 2 flits in flight (P=3).
//     -> outputs 0 next cycle, dropped flits never appear, count=4, flit_count=0, errors 0.
//  6. P=0: send_in / credit_in mirrored same cycle; flit_count wraps with FLIT_CNT_WIDTH=4
//     after 16 sends -> 0.

Source files
------------

// File: rtl/noc_link_pkg.sv
// Shared flit bundle and sizing helpers for the pipelined, credit-checked NoC link.
`ifndef NOC_LINK_PKG_SV
`define NOC_LINK_PKG_SV

// Packages cannot take parameters, so the width-dependent flit bundle is provided as a macro.
`define NOC_FLIT_T(DW, FW) struct packed { logic send; logic is_tail; logic [(DW)-1:0] dest; logic [(FW)-1:0] data; }

package noc_link_pkg;

    localparam int FLIT_CTRL_W = 2;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int flit_bits(input int dest_w, input int flit_w);
        return FLIT_CTRL_W + dest_w + flit_w;
    endfunction

endpackage

`endif

// File: rtl/noc_link_stage.sv
// One retiming stage of the link: a forward flit register and a backward credit register.
module noc_link_stage #(
    parameter int FLIT_W = 40
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [FLIT_W-1:0] i_flit,
    output logic [FLIT_W-1:0] o_flit,
    input  logic              i_credit,
    output logic              o_credit
);

    logic [FLIT_W-1:0] r_flit;
    logic              r_credit;

    // Stage boundary: both directions load unconditionally every cycle; reset drops in-flight traffic.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_flit   <= '0;
            r_credit <= 1'b0;
        end else begin
            r_flit   <= i_flit;
            r_credit <= i_credit;
        end
    end

    assign o_flit   = r_flit;
    assign o_credit = r_credit;

endmodule

// File: rtl/noc_credit_link.sv
// Router-to-router link: NUM_PIPELINE retiming stages each way plus upstream credit and flit monitors.
module noc_credit_link
    import noc_link_pkg::*;
#(
    parameter int NUM_PIPELINE      = 0,
    parameter int FLIT_WIDTH        = 32,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4,
    parameter int FLIT_CNT_WIDTH    = 32,
    localparam int CNT_W            = cnt_width(FLIT_BUFFER_DEPTH)
) (
    input  logic                      clk_noc,
    input  logic                      rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0]     data_in,
    input  logic [DEST_WIDTH-1:0]     dest_in,
    input  logic                      is_tail_in,
    input  logic                      send_in,
    output logic                      credit_out,
    output logic [FLIT_WIDTH-1:0]     data_out,
    output logic [DEST_WIDTH-1:0]     dest_out,
    output logic                      is_tail_out,
    output logic                      send_out,
    input  logic                      credit_in,
    output logic [CNT_W-1:0]          credit_count,
    output logic                      err_underflow,
    output logic                      err_overflow,
    output logic [FLIT_CNT_WIDTH-1:0] flit_count
);

    typedef `NOC_FLIT_T(DEST_WIDTH, FLIT_WIDTH) flit_t;

    localparam int                FW      = flit_bits(DEST_WIDTH, FLIT_WIDTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FLIT_BUFFER_DEPTH);

    flit_t w_flit_in;
    flit_t w_flit_out;

    assign w_flit_in = {send_in, is_tail_in, dest_in, data_in};

    // Full throughput needs FLIT_BUFFER_DEPTH >= 2*NUM_PIPELINE + router round trip; not checked here.
    generate
        if (NUM_PIPELINE == 0) begin : g_wire
            assign w_flit_out = w_flit_in;
            assign credit_out = credit_in;
        end else begin : g_pipe
            logic [FW-1:0]         w_flit_chain [NUM_PIPELINE+1];
            logic [NUM_PIPELINE:0] w_credit_chain;

            assign w_flit_chain[0]              = w_flit_in;
            assign w_credit_chain[NUM_PIPELINE] = credit_in;

            for (genvar i = 0; i < NUM_PIPELINE; i++) begin : g_stage
                noc_link_stage #(
                    .FLIT_W (FW)
                ) u_stage (
                    .i_clk    (clk_noc),
                    .i_rst    (rst_noc_sync),
                    .i_flit   (w_flit_chain[i]),
                    .o_flit   (w_flit_chain[i+1]),
                    .i_credit (w_credit_chain[i+1]),
                    .o_credit (w_credit_chain[i])
                );
            end

            assign w_flit_out = w_flit_chain[NUM_PIPELINE];
            assign credit_out = w_credit_chain[0];
        end
    endgenerate

    assign send_out    = w_flit_out.send;
    assign is_tail_out = w_flit_out.is_tail;
    assign dest_out    = w_flit_out.dest;
    assign data_out    = w_flit_out.data;

    logic [CNT_W-1:0]          r_credit_count;
    logic                      r_err_underflow;
    logic                      r_err_overflow;
    logic [FLIT_CNT_WIDTH-1:0] r_flit_count;

    // Monitor boundary: balance seen by the upstream router; a send and a returning credit cancel.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_credit_count  <= DEPTH_C;
            r_err_underflow <= 1'b0;
            r_err_overflow  <= 1'b0;
            r_flit_count    <= '0;
        end else begin
            unique case ({send_in, credit_out})
                2'b10: begin
                    if (r_credit_count == '0) r_err_underflow <= 1'b1;
                    else                      r_credit_count  <= r_credit_count - CNT_W'(1);
                end
                2'b01: begin
                    if (r_credit_count == DEPTH_C) r_err_overflow <= 1'b1;
                    else                           r_credit_count <= r_credit_count + CNT_W'(1);
                end
                default: ;
            endcase
            r_flit_count <= r_flit_count + FLIT_CNT_WIDTH'(send_in);
        end
    end

    assign credit_count  = r_credit_count;
    assign err_underflow = r_err_underflow;
    assign err_overflow  = r_err_overflow;
    assign flit_count    = r_flit_count;

endmodule
